// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 memory slave.
package apb4_pkg;

  // Transfer sequencing states of the completer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Error response encoding driven on Pslverr
  typedef enum logic {
    RESP_OKAY   = 1'b0,
    RESP_SLVERR = 1'b1
  } resp_t;

  // Default data width and the lane/offset widths derived from it
  localparam int unsigned DSIZE_DEF = 32;
  localparam int unsigned STRB_W    = DSIZE_DEF / 8;
  localparam int unsigned OFF_W     = $clog2(STRB_W);

  // Width helpers for instances that override the data width
  function automatic int unsigned strb_width(input int unsigned dsize);
    return dsize / 8;
  endfunction

  function automatic int unsigned off_width(input int unsigned dsize);
    return $clog2(dsize / 8);
  endfunction

endpackage

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a requester and the memory completer.
interface apb4_mem_slave_if
  import apb4_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned ASIZE = 32
);
  logic                            Psel;
  logic                            Penable;
  logic                            Pwrite;
  logic [ASIZE-1:0]                Paddr;
  logic [DSIZE-1:0]                Pwdata;
  logic [strb_width(DSIZE)-1:0]    Pstrb;
  logic [DSIZE-1:0]                Prdata;
  logic                            Pready;
  logic                            Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, Pwdata, Pstrb,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, Pwdata, Pstrb,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_byte_mem.sv
// Byte-enabled single-port word array: synchronous write, asynchronous read,
// synchronous clear of every word.
module apb_byte_mem #(
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [DSIZE/8-1:0]   strb,
  input  logic [IDX_W-1:0]     addr,
  input  logic [DSIZE-1:0]     wdata,
  output logic [DSIZE-1:0]     rdata
);
  logic [DSIZE-1:0] mem [MEM_DEPTH];

  // Clear has priority over a write; only strobed lanes are updated
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < DSIZE/8; b++) begin
        if (strb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory completer: base-address decode, programmable wait states,
// byte-strobed writes and error response for misaligned/out-of-range access.
module apb4_mem_slave
  import apb4_pkg::*;
#(
  parameter int unsigned       DSIZE       = 32,
  parameter int unsigned       ASIZE       = 32,
  parameter int unsigned       MEM_DEPTH   = 16,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [ASIZE-1:0]  BASE_ADDR   = '0
) (
  input logic              Pclk,
  input logic              Presetn,
  apb4_mem_slave_if.slave  apb
);
  localparam int unsigned    SW    = strb_width(DSIZE);
  localparam int unsigned    OW    = off_width(DSIZE);
  localparam int unsigned    IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ASIZE:0] LIMIT = (ASIZE+1)'(MEM_DEPTH * SW);

  state_t            state;
  logic [3:0]        wcnt;
  logic              pready_q;
  logic              pslverr_q;
  logic [DSIZE-1:0]  prdata_q;

  logic [IDX_W-1:0]  lat_idx;
  logic              lat_wr;
  logic              lat_err;
  logic [DSIZE-1:0]  lat_wdata;
  logic [SW-1:0]     lat_strb;

  logic [ASIZE-1:0]  offset;
  logic              dec_below;
  logic              dec_range;
  logic              dec_mis;
  logic              dec_err;
  logic [IDX_W-1:0]  dec_idx;

  logic              cur_err;
  logic              cur_wr;
  logic [IDX_W-1:0]  mem_addr;
  logic [DSIZE-1:0]  mem_rdata;
  logic              mem_we;
  logic [DSIZE-1:0]  done_rdata;
  logic              done_resp;

  assign offset    = apb.Paddr - BASE_ADDR;
  assign dec_below = apb.Paddr < BASE_ADDR;
  assign dec_range = {1'b0, offset} >= LIMIT;
  assign dec_err   = dec_below | dec_range | dec_mis;
  assign dec_idx   = IDX_W'(offset >> OW);

  generate
    if (OW > 0) begin : g_align
      assign dec_mis = |offset[OW-1:0];
    end else begin : g_no_align
      assign dec_mis = 1'b0;
    end
  endgenerate

  // From IDLE the transfer goes straight to DONE using the live decode, so the
  // memory address and response source switch to the latched copy afterwards.
  always_comb begin
    cur_err  = lat_err;
    cur_wr   = lat_wr;
    mem_addr = lat_idx;
    if (state == IDLE) begin
      cur_err  = dec_err;
      cur_wr   = apb.Pwrite;
      mem_addr = dec_idx;
    end
    done_rdata = (!cur_wr && !cur_err) ? mem_rdata : '0;
    done_resp  = cur_err ? RESP_SLVERR : RESP_OKAY;
  end

  // Memory is only written on the edge that closes a completed good write
  assign mem_we = (state == DONE) && apb.Psel && apb.Penable && lat_wr && !lat_err;

  apb_byte_mem #(
    .DSIZE     (DSIZE),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (Pclk),
    .clr   (!Presetn),
    .we    (mem_we),
    .strb  (lat_strb),
    .addr  (mem_addr),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  // Transfer FSM with wait counter and registered response outputs
  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      state     <= IDLE;
      wcnt      <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      lat_idx   <= '0;
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
      lat_strb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (apb.Psel && !apb.Penable) begin
            lat_idx   <= dec_idx;
            lat_wr    <= apb.Pwrite;
            lat_err   <= dec_err;
            lat_wdata <= apb.Pwdata;
            lat_strb  <= apb.Pstrb;
            if (WAIT_CYCLES == 0) begin
              state     <= DONE;
              pready_q  <= 1'b1;
              pslverr_q <= done_resp;
              prdata_q  <= done_rdata;
            end else begin
              wcnt  <= 4'(WAIT_CYCLES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!apb.Psel || !apb.Penable) begin
            state     <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end else if (wcnt == 4'd0) begin
            state     <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= done_resp;
            prdata_q  <= done_rdata;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
        default: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
      endcase
    end
  end

  assign apb.Pready  = pready_q;
  assign apb.Pslverr = pslverr_q;
  assign apb.Prdata  = prdata_q;
endmodule

// File: tb/tb_apb4_mem_slave.sv
// Self-checking bench: four slave configurations on one clock, a directed
// vector table, abort/reset sequences and randomized traffic vs. a word model.
module tb_apb4_mem_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  rdy;
  logic [3:0]  serr;
  logic [31:0] rdat [4];

  int checks = 0;
  int errors = 0;

  int          wcv   [4] = '{0, 3, 2, 1};
  logic [31:0] basev [4] = '{32'h0, 32'h0, 32'h0, 32'h1000};
  logic [31:0] mdl   [4][16];

  always #5 clk = ~clk;

  apb4_mem_slave_if #(.DSIZE(32), .ASIZE(32)) bus0 ();
  apb4_mem_slave_if #(.DSIZE(32), .ASIZE(32)) bus1 ();
  apb4_mem_slave_if #(.DSIZE(32), .ASIZE(32)) bus2 ();
  apb4_mem_slave_if #(.DSIZE(32), .ASIZE(32)) bus3 ();

  assign bus0.Psel = sel[0]; assign bus0.Penable = penable; assign bus0.Pwrite = pwrite;
  assign bus0.Paddr = paddr; assign bus0.Pwdata = pwdata; assign bus0.Pstrb = pstrb;
  assign bus1.Psel = sel[1]; assign bus1.Penable = penable; assign bus1.Pwrite = pwrite;
  assign bus1.Paddr = paddr; assign bus1.Pwdata = pwdata; assign bus1.Pstrb = pstrb;
  assign bus2.Psel = sel[2]; assign bus2.Penable = penable; assign bus2.Pwrite = pwrite;
  assign bus2.Paddr = paddr; assign bus2.Pwdata = pwdata; assign bus2.Pstrb = pstrb;
  assign bus3.Psel = sel[3]; assign bus3.Penable = penable; assign bus3.Pwrite = pwrite;
  assign bus3.Paddr = paddr; assign bus3.Pwdata = pwdata; assign bus3.Pstrb = pstrb;

  assign rdy[0] = bus0.Pready; assign serr[0] = bus0.Pslverr; assign rdat[0] = bus0.Prdata;
  assign rdy[1] = bus1.Pready; assign serr[1] = bus1.Pslverr; assign rdat[1] = bus1.Prdata;
  assign rdy[2] = bus2.Pready; assign serr[2] = bus2.Pslverr; assign rdat[2] = bus2.Prdata;
  assign rdy[3] = bus3.Pready; assign serr[3] = bus3.Pslverr; assign rdat[3] = bus3.Prdata;

  apb4_mem_slave #(.DSIZE(32), .ASIZE(32), .MEM_DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0))
    dut0 (.Pclk(clk), .Presetn(rst_n), .apb(bus0));
  apb4_mem_slave #(.DSIZE(32), .ASIZE(32), .MEM_DEPTH(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0))
    dut1 (.Pclk(clk), .Presetn(rst_n), .apb(bus1));
  apb4_mem_slave #(.DSIZE(32), .ASIZE(32), .MEM_DEPTH(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0))
    dut2 (.Pclk(clk), .Presetn(rst_n), .apb(bus2));
  apb4_mem_slave #(.DSIZE(32), .ASIZE(32), .MEM_DEPTH(16), .WAIT_CYCLES(1), .BASE_ADDR(32'h1000))
    dut3 (.Pclk(clk), .Presetn(rst_n), .apb(bus3));

  typedef struct {
    int          k;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit model_err(input int k, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - basev[k];
    return (addr < basev[k]) || (off % 4 != 0) || (off >= 32'd64);
  endfunction

  function automatic int model_idx(input int k, input logic [31:0] addr);
    return int'((addr - basev[k]) / 4);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++)
        mdl[k][i] = 32'h0;
  endfunction

  // One transfer on slave k; starts and ends just after a rising edge.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int abort_at,
                      output bit got, output int waits, output bit err,
                      output logic [31:0] rd, output bit proto_ok);
    int lim;
    got = 1'b0; waits = 0; err = 1'b0; rd = '0; proto_ok = 1'b1;
    sel = '0; sel[k] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    if (rdy[k] || serr[k]) proto_ok = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    lim = wcv[k] + 4;
    for (int c = 0; c < lim && !got; c++) begin
      if (c == abort_at) begin
        sel = '0; penable = 1'b0;
      end
      @(negedge clk);
      if (rdy[k]) begin
        got = 1'b1; waits = c; err = serr[k]; rd = rdat[k];
      end else if (serr[k] || rdat[k] != 32'h0) begin
        proto_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    sel = '0; penable = 1'b0;
  endtask

  // Transfer checked against the model; the model is updated on good writes.
  task automatic do_op(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input string name,
                       output bit err_o, output logic [31:0] rd_o);
    bit got, p, e_exp;
    int w;
    logic [31:0] rd_exp;
    e_exp  = model_err(k, addr);
    rd_exp = (wr || e_exp) ? 32'h0 : mdl[k][model_idx(k, addr)];
    xfer(k, wr, addr, data, strb, -1, got, w, err_o, rd_o, p);
    chk({name, "_ready"}, 32'(got), 32'd1);
    chk({name, "_waits"}, w, wcv[k]);
    chk({name, "_slverr"}, 32'(err_o), 32'(e_exp));
    if (!wr) chk({name, "_rdata"}, rd_o, rd_exp);
    chk({name, "_proto"}, 32'(p), 32'd1);
    if (wr && !e_exp) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[k][model_idx(k, addr)][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic idle(input int n);
    sel = '0; penable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_quiet", {24'h0, rdy, serr}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [$];
    bit          e, got, p;
    int          w;
    logic [31:0] r, a;
    int          k, cls;

    rst_n = 1'b0; sel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_out%0d", i), {30'h0, rdy[i], serr[i]}, 32'h0);
      chk($sformatf("reset_rdata%0d", i), rdat[i], 32'h0);
    end
    @(posedge clk); #1;

    tbl.push_back('{0, 1'b0, 32'h0000, 32'h0,        4'h0, 1'b0, 32'h00000000});
    tbl.push_back('{0, 1'b1, 32'h0008, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h0008, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b1, 32'h0008, 32'h11223344, 4'h5, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h0008, 32'h0,        4'h0, 1'b0, 32'hDE22BE44});
    tbl.push_back('{1, 1'b1, 32'h0004, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b0, 32'h0004, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5});
    tbl.push_back('{0, 1'b1, 32'h0040, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h0002, 32'h0,        4'h0, 1'b1, 32'h00000000});
    tbl.push_back('{3, 1'b0, 32'h0FFC, 32'h0,        4'h0, 1'b1, 32'h00000000});
    tbl.push_back('{3, 1'b1, 32'h1004, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{3, 1'b0, 32'h1004, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D});
    tbl.push_back('{3, 1'b0, 32'h1040, 32'h0,        4'h0, 1'b1, 32'h00000000});
    tbl.push_back('{0, 1'b1, 32'h0010, 32'h12345678, 4'h0, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 32'h0010, 32'h0,        4'h0, 1'b0, 32'h00000000});
    tbl.push_back('{0, 1'b0, 32'h003C, 32'h0,        4'h0, 1'b0, 32'h00000000});
    tbl.push_back('{0, 1'b0, 32'h003E, 32'h0,        4'h0, 1'b1, 32'h00000000});

    foreach (tbl[i]) begin
      do_op(tbl[i].k, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb,
            $sformatf("tbl%0d", i), e, r);
      chk($sformatf("tbl%0d_vec_err", i), 32'(e), 32'(tbl[i].eerr));
      if (!tbl[i].wr) chk($sformatf("tbl%0d_vec_rdata", i), r, tbl[i].erd);
    end

    // Rejected write at 0x40 must leave every word of slave 0 untouched
    idle(1);
    for (int i = 0; i < 16; i++)
      do_op(0, 1'b0, 32'(4*i), 32'h0, 4'h0, $sformatf("scan%0d", i), e, r);

    // Requester drops Psel during WAIT: no completion, no write
    do_op(2, 1'b1, 32'h000C, 32'h0BADC0DE, 4'hF, "abort_pre", e, r);
    xfer(2, 1'b1, 32'h000C, 32'h12345678, 4'hF, 1, got, w, e, r, p);
    chk("abort_no_ready", 32'(got), 32'd0);
    chk("abort_proto", 32'(p), 32'd1);
    idle(2);
    do_op(2, 1'b0, 32'h000C, 32'h0, 4'h0, "abort_read", e, r);
    chk("abort_keep", r, 32'h0BADC0DE);

    // Reset pulse during WAIT of a write on the 3-wait slave
    sel = '0; sel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8; pwdata = 32'h77777777; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; sel = '0; penable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_mid_out%0d", i), {30'h0, rdy[i], serr[i]}, 32'h0);
      chk($sformatf("rst_mid_rdata%0d", i), rdat[i], 32'h0);
    end
    @(posedge clk); #1;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      do_op(1, 1'b0, 32'(4*i), 32'h0, 4'h0, $sformatf("rst_scan%0d", i), e, r);
      chk($sformatf("rst_zero%0d", i), r, 32'h0);
    end
    do_op(3, 1'b0, 32'h1004, 32'h0, 4'h0, "rst_scan_b", e, r);

    // Randomized traffic over all four configurations
    for (int n = 0; n < 300; n++) begin
      k   = int'($urandom_range(0, 3));
      cls = int'($urandom_range(0, 9));
      if (cls <= 6)      a = basev[k] + 4 * $urandom_range(0, 15);
      else if (cls == 7) a = basev[k] + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (cls == 8) a = basev[k] + 64 + 4 * $urandom_range(0, 15);
      else               a = basev[k] - 4 * $urandom_range(1, 4);
      do_op(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            $sformatf("rnd%0d", n), e, r);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(1);
    for (int kk = 0; kk < 4; kk++)
      for (int i = 0; i < 16; i++)
        do_op(kk, 1'b0, basev[kk] + 32'(4*i), 32'h0, 4'h0, $sformatf("final%0d_%0d", kk, i), e, r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

Parametrised APB4 memory slave succeeding the bare write/read APB memory model. It implements the full APB4 completer handshake: Psel/Penable phases, Pready with programmable wait states, Pstrb byte-lane writes, address decode against a base address, and Pslverr for out-of-range or misaligned accesses. It sits behind the AHB-to-APB bridge as the APB-side target for bridge verification.

## Interface
- DSIZE, 32: data width in bits; must be 8, 16, 32 or 64.
- ASIZE, 32: address width in bits.
- MEM_DEPTH, 16: number of DSIZE-bit words.
- WAIT_CYCLES, 0: extra ACCESS cycles inserted before Pready; range 0..15.
- BASE_ADDR, 0: byte address of word 0; must be aligned to DSIZE/8.
- Pclk  in  1  clock; all logic on rising edge.
- Presetn  in  1  reset, synchronous, active-low.
- Psel  in  1  slave select.
- Penable  in  1  ACCESS phase indicator.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  ASIZE  byte address.
- Pwdata  in  DSIZE  write data.
- Pstrb  in  DSIZE/8  write byte strobes; ignored on reads.
- Prdata  out  DSIZE  read data.
- Pready  out  1  transfer completes in this cycle.
- Pslverr  out  1  error response; valid only while Pready=1.

## Operation
- Decode: offset = Paddr - BASE_ADDR. The access is an error if offset[log2(DSIZE/8)-1:0] != 0, if Paddr < BASE_ADDR, or if offset >= MEM_DEPTH*DSIZE/8. Word index = offset >> log2(DSIZE/8).
- FSM states are IDLE, WAIT and DONE. All outputs are registered.
- IDLE: the SETUP phase is sampled as Psel=1 and Penable=0. On that edge, latch the address, direction, data, strobes and the error flag. Go to DONE if WAIT_CYCLES=0; otherwise load wcnt=WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement wcnt each cycle. When wcnt=0, go to DONE.
- Entry to DONE sets Pready=1 and Pslverr=error flag. On a good read, it also sets Prdata=mem[index]. On an error read, Prdata=0.
- DONE lasts one cycle. On its closing edge, with Psel=1, Penable=1 and Pready=1:
  - A good write updates each byte lane i where Pstrb[i]=1.
  - An error write changes nothing.
  - The FSM returns to IDLE.
  - Pready, Pslverr and Prdata are cleared to 0.
- Abort: if Psel=0 or Penable=0 in WAIT or DONE (a requester violation), go to IDLE. No memory write occurs and outputs are cleared.
- A write with Pstrb=0 is a legal no-op with no error.
- Back-to-back transfers are allowed: the edge closing DONE returns the FSM to IDLE, and the next SETUP is sampled from IDLE.
- Reset with Presetn=0 at any edge, including mid-transfer:
  - The FSM goes to IDLE.
  - Pready, Pslverr and Prdata are all set to 0.
  - All memory words are set to 0.
  - Any pending write is discarded.

## Timing
- Transfer length is SETUP (1 cycle) plus ACCESS (WAIT_CYCLES+1 cycles).
- With WAIT_CYCLES=0 this is a zero-wait transfer: Pready is high in the first ACCESS cycle.
- Read data is valid in the same cycle as Pready=1.
- Written data is readable by any transfer whose SETUP follows the write's completing edge.
- Pready is never high for more than one consecutive cycle.
- Pready is never high outside ACCESS.
- Pslverr is 0 whenever Pready=0.

## Structure
- Package apb4_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the strobe width localparam DSIZE/8;
  - the byte-offset width localparam log2(DSIZE/8);
  - the error-response encoding.
- Sub-module apb_byte_mem is the byte-enabled, single-port, synchronous-write, MEM_DEPTH x DSIZE array with synchronous zero clear. It holds all memory state.
- The FSM, decode and wait counter live in the top module.

## Test plan
- Reset, then read at offset 0x0 with WAIT_CYCLES=0 -> Pready high in the first ACCESS cycle, Prdata=0x00000000, Pslverr=0.
- Write 0xDEADBEEF to 0x8 with Pstrb=0xF, then read 0x8 -> Prdata=0xDEADBEEF. Next, write 0x11223344 to 0x8 with Pstrb=0x5, then read 0x8 -> Prdata=0xDE22BE44.
- WAIT_CYCLES=3: write 0xA5A5A5A5 to 0x4 -> Pready low for 3 ACCESS cycles and high in the 4th. A following read of 0x4 -> Prdata=0xA5A5A5A5.
- Error cases:
  - Write to 0x40 (MEM_DEPTH=16, DSIZE=32) -> Pslverr=1 with Pready, and no word changes.
  - Read at 0x2 (misaligned) -> Pslverr=1, Prdata=0.
  - BASE_ADDR=0x1000, read at 0x0FFC -> Pslverr=1.
- WAIT_CYCLES=2: drop Psel during WAIT of a write of 0x12345678 to 0xC -> no Pready pulse, and a later read of 0xC returns the prior value.
- Assert Presetn=0 for one cycle during WAIT of a write -> outputs are 0 the following cycle, and a subsequent read of any word returns 0.
